// File: rtl/alu_seq_exec.sv
// alu_seq_exec: sequential ALU with a valid/ready request/result handshake.
// It decodes {aluop, funct3, funct7b5} and executes one operation at a time.
// Single-cycle operations finish one cycle after accept. Shifts iterate SHIFT_STEP bits per cycle.
// Optional feature: define ALU_SEQ_MUL_EN to execute aluop=11 as an iterative shift-add MUL.
// Without that macro, aluop=11 reports illegal and no multiplier logic is built.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no work in progress; a finished result may be held (o_out_valid)
// S_SHIFT | iterative shift, r_rem bits still to go
// S_MUL   | iterative multiply, r_cnt multiplier bits still to go
//
// "DONE" is S_IDLE with o_out_valid high. This lets the result drain and a
// new accept happen on the same edge.

module alu_seq_exec #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [1:0]      i_aluop,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7b5,
    input  logic            i_is_rtype,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_illegal,
    output logic            o_busy
);

    localparam int            SH_W     = $clog2(XLEN);
    localparam logic [SH_W:0] STEP_MAX = (SH_W+1)'(SHIFT_STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;
    logic              r_illegal;
    logic [XLEN-1:0]   r_acc;
    logic [SH_W:0]     r_rem;
    logic              r_shift_left;
    logic              r_shift_arith;
`ifdef ALU_SEQ_MUL_EN
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [SH_W:0]     r_cnt;
    logic [XLEN-1:0]   w_mul_sum;
`endif

    logic              w_accept;
    logic [XLEN-1:0]   w_res;
    logic              w_illegal;
    logic              w_is_shift;
    logic              w_is_mul;
    logic              w_dec_left;
    logic              w_dec_arith;
    logic [SH_W-1:0]   w_shamt;
    logic [SH_W:0]     w_step;
    logic [XLEN-1:0]   w_shifted;

    assign o_in_ready  = (r_state == S_IDLE) && (!r_out_valid || i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_shamt     = i_op_b[SH_W-1:0];
    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_zero      = r_zero;
    assign o_illegal   = r_illegal;
    assign o_busy      = (r_state != S_IDLE) || r_out_valid;

    // Decode the incoming request and compute every single-cycle result.
    // A shift by zero also finishes here and returns op_a.
    always_comb begin
        w_res       = '0;
        w_illegal   = 1'b0;
        w_is_shift  = 1'b0;
        w_is_mul    = 1'b0;
        w_dec_left  = 1'b0;
        w_dec_arith = 1'b0;
        case (i_aluop)
            2'b00: w_res = i_op_a + i_op_b;
            2'b01: w_res = i_op_a - i_op_b;
            2'b10: begin
                case (i_funct3)
                    3'b000: w_res = (i_is_rtype && i_funct7b5) ? (i_op_a - i_op_b) : (i_op_a + i_op_b);
                    3'b001: begin
                        if (i_funct7b5) begin
                            w_illegal = 1'b1;
                        end else begin
                            w_is_shift = 1'b1;
                            w_dec_left = 1'b1;
                            w_res      = i_op_a;
                        end
                    end
                    3'b010: w_res = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
                    3'b011: w_res = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
                    3'b100: w_res = i_op_a ^ i_op_b;
                    3'b101: begin
                        // For I-type shifts, immediate bits above the shift field must be clear.
                        if (!i_is_rtype && (|i_op_b[XLEN-1:SH_W+1])) begin
                            w_illegal = 1'b1;
                        end else begin
                            w_is_shift  = 1'b1;
                            w_dec_arith = i_funct7b5;
                            w_res       = i_op_a;
                        end
                    end
                    3'b110: w_res = i_op_a | i_op_b;
                    default: w_res = i_op_a & i_op_b;
                endcase
            end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                w_is_mul  = 1'b1;
`else
                w_illegal = 1'b1;
`endif
            end
        endcase
    end

    // One shift iteration: move by min(remaining, SHIFT_STEP).
    // For SRA, the sign of r_acc stays the sign of op_a, so each step refills with that sign bit.
    always_comb begin
        w_step = (r_rem > STEP_MAX) ? STEP_MAX : r_rem;
        if (r_shift_left) begin
            w_shifted = r_acc << w_step;
        end else if (r_shift_arith) begin
            w_shifted = $signed(r_acc) >>> w_step;
        end else begin
            w_shifted = r_acc >> w_step;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    // One shift-add multiply iteration, one multiplier bit per cycle.
    always_comb begin
        w_mul_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    end
`endif

    // Control FSM. The result, flags and out_valid are all registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_out_valid   <= 1'b0;
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_illegal     <= 1'b0;
            r_acc         <= '0;
            r_rem         <= '0;
            r_shift_left  <= 1'b0;
            r_shift_arith <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_cnt         <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_state       <= S_SHIFT;
                            r_out_valid   <= 1'b0;
                            r_acc         <= i_op_a;
                            r_rem         <= {1'b0, w_shamt};
                            r_shift_left  <= w_dec_left;
                            r_shift_arith <= w_dec_arith;
`ifdef ALU_SEQ_MUL_EN
                        end else if (w_is_mul) begin
                            r_state       <= S_MUL;
                            r_out_valid   <= 1'b0;
                            r_acc         <= '0;
                            r_mcand       <= i_op_a;
                            r_mplier      <= i_op_b;
                            r_cnt         <= (SH_W+1)'(XLEN);
`endif
                        end else begin
                            r_out_valid   <= 1'b1;
                            r_result      <= w_res;
                            r_zero        <= (w_res == '0);
                            r_illegal     <= w_illegal;
                        end
                    end else if (r_out_valid && i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_shifted;
                    r_rem <= r_rem - w_step;
                    if (r_rem == w_step) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_shifted;
                        r_zero      <= (w_shifted == '0);
                        r_illegal   <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                S_MUL: begin
                    r_acc    <= w_mul_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == (SH_W+1)'(1)) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_mul_sum;
                        r_zero      <= (w_mul_sum == '0);
                        r_illegal   <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: self-checking bench for alu_seq_exec (XLEN=32, SHIFT_STEP=4).
// Uses directed vectors, hand-written handshake/reset sequences and random ops against a reference model.

module tb_alu_seq_exec;

    localparam int XLEN = 32;
    localparam int STEP = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      aluop;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            is_rtype;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    int n_tests;
    int n_fail;

    alu_seq_exec #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_aluop     (aluop),
        .i_funct3    (funct3),
        .i_funct7b5  (funct7b5),
        .i_is_rtype  (is_rtype),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_zero      (zero),
        .o_illegal   (illegal),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        b5;
        logic        rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zr;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model built from the operation rules, using plain arithmetic.
    function automatic void ref_model(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                                      input logic rt, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic il, output int lat);
        int sh;
        sh  = int'(b & 32'd31);
        r   = 32'd0;
        il  = 1'b0;
        lat = 1;
        case (op)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd2: begin
                case (f3)
                    3'd0: r = (rt && b5) ? a - b : a + b;
                    3'd1: if (b5) il = 1'b1;
                          else begin r = a << sh; lat = 1 + (sh + STEP - 1) / STEP; end
                    3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: r = (a < b) ? 32'd1 : 32'd0;
                    3'd4: r = a ^ b;
                    3'd5: if (!rt && ((b >> 6) != 32'd0)) il = 1'b1;
                          else begin
                              r = b5 ? 32'($signed(a) >>> sh) : (a >> sh);
                              lat = 1 + (sh + STEP - 1) / STEP;
                          end
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
            end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                r   = a * b;
                lat = XLEN + 1;
`else
                il  = 1'b1;
`endif
            end
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic b5, input logic rt,
                         input logic [31:0] a, input logic [31:0] b);
        aluop = op; funct3 = f3; funct7b5 = b5; is_rtype = rt; op_a = a; op_b = b;
    endtask

    // Issue one request, then measure cycles from accept to out_valid and capture the result.
    // Then hold off draining for drain_wait cycles before accepting the result.
    task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic b5, input logic rt,
                          input logic [31:0] a, input logic [31:0] b, input int drain_wait,
                          output logic [31:0] r, output logic z, output logic il, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 200) check("in_ready_timeout", 32'(in_ready), 32'd1);
        drive(op, f3, b5, rt, a, b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        r = result; z = zero; il = illegal;
        repeat (drain_wait) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic b5, input logic rt,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                                input logic ill, input int lat);
        vec_t v;
        v.op = op; v.f3 = f3; v.b5 = b5; v.rt = rt; v.a = a; v.b = b;
        v.res = res; v.zr = (res == 32'd0); v.ill = ill; v.lat = lat;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r, er, ra, rb;
        logic        z, il, eil, seen;
        logic [1:0]  rop;
        logic [2:0]  rf3;
        logic        rb5, rrt;
        int          lat, elat;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(2'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors
        vecs.push_back(mk(2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1));
        vecs.push_back(mk(2'b01, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'd0, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd9, 32'hFFC0_0000, 1'b0, 4));
        vecs.push_back(mk(2'b10, 3'b101, 1'b0, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b001, 1'b1, 1'b1, 32'h1234_5678, 32'd3, 32'd0, 1'b1, 1));
        vecs.push_back(mk(2'b10, 3'b101, 1'b0, 1'b0, 32'h1234_5678, 32'h40, 32'd0, 1'b1, 1));
        vecs.push_back(mk(2'b10, 3'b101, 1'b0, 1'b0, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b001, 1'b0, 1'b0, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 9));
        vecs.push_back(mk(2'b10, 3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 2));
        vecs.push_back(mk(2'b10, 3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'd5, 32'h0400_0000, 1'b0, 3));
        vecs.push_back(mk(2'b00, 3'b111, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b110, 1'b0, 1'b1, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1));
        vecs.push_back(mk(2'b10, 3'b111, 1'b0, 1'b1, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h00F0_00FF, 1'b0, 1));
`ifdef ALU_SEQ_MUL_EN
        vecs.push_back(mk(2'b11, 3'b000, 1'b0, 1'b0, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33));
`else
        vecs.push_back(mk(2'b11, 3'b000, 1'b0, 1'b0, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b1, 1));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].f3, vecs[i].b5, vecs[i].rt, vecs[i].a, vecs[i].b, 0, r, z, il, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].zr));
            check($sformatf("vec%0d_illegal", i), 32'(il), 32'(vecs[i].ill));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: result held stable, then drain and re-accept on the same edge
        drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd10, 32'd20);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_first_valid", 32'(out_valid), 32'd1);
        check("bp_first_result", result, 32'd30);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_result", i), result, 32'd30);
            check($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold%0d_busy", i), 32'(busy), 32'd1);
        end
        drive(2'b10, 3'b100, 1'b0, 1'b1, 32'hF0, 32'h0F);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_reaccept_valid", 32'(out_valid), 32'd1);
        check("bp_reaccept_result", result, 32'hFF);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_drained_valid", 32'(out_valid), 32'd0);
        check("bp_drained_busy", 32'(busy), 32'd0);

        // A request held during a shift is ignored, then taken on the drain edge
        drive(2'b10, 3'b101, 1'b0, 1'b1, 32'hFFFF_0000, 32'd8);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2);
        check("hold_shift_in_ready", 32'(in_ready), 32'd0);
        check("hold_shift_busy", 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("hold_shift_latency", 32'(lat), 32'd3);
        check("hold_shift_result", result, 32'h00FF_FF00);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("hold_next_valid", 32'(out_valid), 32'd1);
        check("hold_next_result", result, 32'd3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a long shift
        drive(2'b10, 3'b001, 1'b0, 1'b1, 32'd1, 32'd31);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("midrst_no_stale_valid", 32'(seen), 32'd0);
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);

        // Random operations against the reference model
        for (int i = 0; i < 200; i++) begin
            rop = 2'($urandom_range(0, 3));
            rf3 = 3'($urandom_range(0, 7));
            rb5 = 1'($urandom_range(0, 1));
            rrt = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 63));
                1: rb = ra;
                default: rb = $urandom;
            endcase
            ref_model(rop, rf3, rb5, rrt, ra, rb, er, eil, elat);
            run_op(rop, rf3, rb5, rrt, ra, rb, int'($urandom_range(0, 2)), r, z, il, lat);
            check($sformatf("rnd%0d_result op=%0d f3=%0d a=%h b=%h", i, rop, rf3, ra, rb), r, er);
            check($sformatf("rnd%0d_zero", i), 32'(z), 32'(er == 32'd0));
            check($sformatf("rnd%0d_illegal", i), 32'(il), 32'(eil));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
